// File: rtl/aclk_controller_multi.sv
// aclk_controller_multi: keypad entry FSM that commits NUM_DIGITS digits to the current time or to one of NUM_ALARMS alarms.
// Optional feature macro ACLK_KEY_RESTART_EN: each accepted key in ENTRY restarts the timeout window.
module aclk_controller_multi #(
  parameter int NUM_DIGITS = 4,
  parameter int TIMEOUT_SECS = 10,
  parameter int NUM_ALARMS = 2,
  parameter logic [3:0] NOKEY = 4'hA,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  one_second,
  input  logic [3:0]            key,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [AW-1:0]         alarm_sel,
  output logic                  shift,
  output logic                  show_new_time,
  output logic [NUM_ALARMS-1:0] show_a,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic                  entry_timeout
);
  typedef enum logic [1:0] {IDLE, ENTRY, SHOW_ALARM} state_t;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_SECS + 1);
  localparam logic [CW-1:0] DMAX = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_SECS - 1);
  localparam logic [AW:0] NA = (AW + 1)'(NUM_ALARMS);
  state_t state_q, state_d;
  logic [3:0] prev_key_q;
  logic [CW-1:0] digit_cnt_q, digit_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic shift_q, shift_d, show_new_time_q, show_new_time_d;
  logic [NUM_ALARMS-1:0] show_a_q, show_a_d, load_new_a_q, load_new_a_d;
  logic load_new_c_q, load_new_c_d, entry_timeout_q, entry_timeout_d;
  logic press, sel_ok, full, timeout, alarm_act;
  logic [NUM_ALARMS-1:0] sel_oh;
  // A press is the first cycle of a valid digit after an idle keypad; out-of-range alarm channels act as a released button
  assign press = (key != NOKEY) && (key <= 4'd9) && (prev_key_q == NOKEY);
  assign sel_ok = {1'b0, alarm_sel} < NA;
  assign sel_oh = sel_ok ? (NUM_ALARMS'(1) << alarm_sel) : '0;
  assign alarm_act = alarm_button && sel_ok;
  assign full = digit_cnt_q == DMAX;
  assign timeout = one_second && (tick_cnt_q >= TLAST);
  // Next state and registered-output values; in ENTRY commit beats timeout beats press
  always_comb begin
    state_d = state_q;
    digit_cnt_d = digit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    shift_d = 1'b0;
    load_new_a_d = '0;
    load_new_c_d = 1'b0;
    entry_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = ENTRY;
          shift_d = 1'b1;
          digit_cnt_d = CW'(1);
          tick_cnt_d = '0;
        end else if (alarm_act) begin
          state_d = SHOW_ALARM;
        end
      end
      SHOW_ALARM: state_d = alarm_act ? SHOW_ALARM : IDLE;
      ENTRY: begin
        if (full && time_button) begin
          load_new_c_d = 1'b1;
          state_d = IDLE;
        end else if (full && alarm_act) begin
          load_new_a_d = sel_oh;
          state_d = IDLE;
        end else if (timeout) begin
          entry_timeout_d = 1'b1;
          state_d = IDLE;
        end else begin
          if (one_second) tick_cnt_d = tick_cnt_q + 1'b1;
          if (press) begin
            shift_d = 1'b1;
            digit_cnt_d = full ? digit_cnt_q : digit_cnt_q + 1'b1;
`ifdef ACLK_KEY_RESTART_EN
            tick_cnt_d = '0;
`else
            tick_cnt_d = tick_cnt_d;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    show_new_time_d = state_d == ENTRY;
    show_a_d = (state_d == SHOW_ALARM) ? sel_oh : '0;
  end
  // State, counters, key history and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prev_key_q <= NOKEY;
      digit_cnt_q <= '0;
      tick_cnt_q <= '0;
      shift_q <= 1'b0;
      show_new_time_q <= 1'b0;
      show_a_q <= '0;
      load_new_a_q <= '0;
      load_new_c_q <= 1'b0;
      entry_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_key_q <= key;
      digit_cnt_q <= digit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      shift_q <= shift_d;
      show_new_time_q <= show_new_time_d;
      show_a_q <= show_a_d;
      load_new_a_q <= load_new_a_d;
      load_new_c_q <= load_new_c_d;
      entry_timeout_q <= entry_timeout_d;
    end
  end
  assign shift = shift_q;
  assign show_new_time = show_new_time_q;
  assign show_a = show_a_q;
  assign load_new_a = load_new_a_q;
  assign load_new_c = load_new_c_q;
  assign reset_count = load_new_c_q;
  assign entry_timeout = entry_timeout_q;
endmodule
